// File: rtl/uart_pkg.sv
// Shared types and defaults for the configurable UART receiver.
package uart_pkg;

  localparam int UART_OVS_DEF = 16;
  localparam int UART_DW_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  function automatic parity_t decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input synchronizer plus three-point majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS = UART_OVS_DEF,
  parameter int SW  = $clog2(OVS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          s_tick,
  input  logic [SW-1:0] s,
  output logic          rx_s,
  output logic          bit_val
);

  localparam logic [SW-1:0] S_VOTE0 = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_VOTE1 = SW'(OVS/2);

  logic r_sync1;
  logic r_sync2;
  logic r_vote0;
  logic r_vote1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_vote0 <= 1'b1;
      r_vote1 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      if (s_tick) begin
        if (s == S_VOTE0) r_vote0 <= r_sync2;
        if (s == S_VOTE1) r_vote1 <= r_sync2;
      end
    end
  end

  assign rx_s = r_sync2;
  // Third vote is the live sample, taken on the commit tick itself.
  assign bit_val = (r_vote0 & r_vote1) | (r_vote0 & r_sync2) | (r_vote1 & r_sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime frame format, majority voting, parity/framing/break status.
// state    | meaning
// IDLE     | line idle, waiting for falling edge
// START    | validating start bit (false-start rejection)
// DATA     | shifting data bits, LSB first
// PARITY   | sampling and checking parity bit
// STOP     | sampling stop bit(s); finishes on last stop commit
// BRK_WAIT | break seen, waiting for line to return high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DW  = UART_DW_DEF,
  parameter int OVS = UART_OVS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          s_tick,
  input  logic [3:0]    cfg_dbits,
  input  logic [1:0]    cfg_parity,
  input  logic          cfg_stop2,
  output logic [DW-1:0] dout,
  output logic          rx_done_tick,
  output logic          parity_err,
  output logic          frame_err,
  output logic          break_det
);

  localparam int SW = $clog2(OVS);
  localparam int NW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [SW-1:0] S_COMMIT = SW'(OVS/2 + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVS - 1);
  localparam logic [3:0]    DBITS_MAX = 4'(DW);

  rx_state_t     r_state;
  parity_t       r_par;
  logic [SW-1:0] r_s;
  logic [NW-1:0] r_n;
  logic [NW-1:0] r_n_last;
  logic [DW-1:0] r_b;
  logic          r_stop2;
  logic          r_stop_idx;
  logic          r_perr;
  logic          r_ferr;
  logic          r_par_bit;
  logic          r_stop1;

  logic          w_rx_s;
  logic          w_bit_val;
  logic          w_commit;
  logic          w_bit_end;
  logic [3:0]    w_dbits_eff;
  logic          w_par_exp;
  logic          w_stop1;
  logic          w_ferr;
  logic          w_brk;
  logic          w_last_stop;

  uart_rx_sampler #(.OVS(OVS), .SW(SW)) u_sampler (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .s_tick  (s_tick),
    .s       (r_s),
    .rx_s    (w_rx_s),
    .bit_val (w_bit_val)
  );

  assign w_commit    = s_tick && (r_s == S_COMMIT);
  assign w_bit_end   = s_tick && (r_s == S_LAST);
  assign w_dbits_eff = (cfg_dbits >= 4'd5 && cfg_dbits <= DBITS_MAX) ? cfg_dbits : DBITS_MAX;
  assign w_par_exp   = (r_par == PAR_ODD) ? ~(^r_b) : (^r_b);
  // Values as they will be once the current stop-bit vote is folded in.
  assign w_stop1     = r_stop_idx ? r_stop1 : w_bit_val;
  assign w_ferr      = r_ferr | ~w_bit_val;
  assign w_brk       = (r_b == '0) && ((r_par == PAR_NONE) || !r_par_bit) && !w_stop1;
  assign w_last_stop = (r_stop_idx == r_stop2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_par        <= PAR_NONE;
      r_s          <= '0;
      r_n          <= '0;
      r_n_last     <= '0;
      r_b          <= '0;
      r_stop2      <= 1'b0;
      r_stop_idx   <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_par_bit    <= 1'b0;
      r_stop1      <= 1'b0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      if (s_tick && (r_state inside {START, DATA, PARITY, STOP}))
        r_s <= (r_s == S_LAST) ? '0 : r_s + SW'(1);

      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state    <= START;
            r_s        <= '0;
            r_n        <= '0;
            r_b        <= '0;
            r_n_last   <= NW'(w_dbits_eff - 4'd1);
            r_par      <= decode_parity(cfg_parity);
            r_stop2    <= cfg_stop2;
            r_stop_idx <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop1    <= 1'b1;
          end
        end
        START: begin
          if (w_commit && w_bit_val) begin
            r_state <= IDLE;
            r_s     <= '0;
          end else if (w_bit_end) begin
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_commit) r_b[r_n] <= w_bit_val;
          if (w_bit_end) begin
            if (r_n == r_n_last) r_state <= (r_par == PAR_NONE) ? STOP : PARITY;
            else                 r_n <= r_n + NW'(1);
          end
        end
        PARITY: begin
          if (w_commit) begin
            r_par_bit <= w_bit_val;
            r_perr    <= w_bit_val ^ w_par_exp;
          end
          if (w_bit_end) r_state <= STOP;
        end
        STOP: begin
          if (w_commit) begin
            r_ferr <= w_ferr;
            if (!r_stop_idx) r_stop1 <= w_bit_val;
            // Finish at the last stop-bit centre so a following start edge is not missed.
            if (w_last_stop) begin
              rx_done_tick <= 1'b1;
              dout         <= w_brk ? '0 : r_b;
              parity_err   <= (r_par != PAR_NONE) && r_perr;
              frame_err    <= w_ferr;
              break_det    <= w_brk;
              r_state      <= w_brk ? BRK_WAIT : IDLE;
              r_s          <= '0;
            end
          end else if (w_bit_end) begin
            r_stop_idx <= 1'b1;
          end
        end
        BRK_WAIT: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frame formats, glitches, break, back-to-back and reset abort.
module tb_uart_rx_cfg;

  localparam int DW      = 8;
  localparam int OVS     = 16;
  localparam int TPB     = 4;
  localparam int BIT_CLK = OVS * TPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          s_tick;
  logic [3:0]    cfg_dbits;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic [DW-1:0] dout;
  logic          rx_done_tick;
  logic          parity_err;
  logic          frame_err;
  logic          break_det;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int last_pulse_cyc = 0;
  int stop_start = 0;
  logic [7:0] cap_q[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(.DW(DW), .OVS(OVS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det)
  );

  always @(negedge clk) begin
    cyc++;
    if (rx_done_tick === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
      cap_q.push_back(dout);
    end
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TPB - 1) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [3:0] d, input logic [1:0] p, input logic s2);
    cfg_dbits  = d;
    cfg_parity = p;
    cfg_stop2  = s2;
  endtask

  // pmode: 0 none, 1 even, 2 odd
  task automatic send_frame(input logic [8:0] data, input int nb, input int pmode,
                            input logic pflip, input logic stop2, input logic stop_v);
    logic p;
    p = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      send_bit(data[i]);
      p ^= data[i];
    end
    if (pmode == 1)      send_bit(p ^ pflip);
    else if (pmode == 2) send_bit(~p ^ pflip);
    if (stop2) begin
      send_bit(stop_v);
      stop_start = cyc;
      send_bit(1'b1);
    end else begin
      stop_start = cyc;
      send_bit(stop_v);
    end
  endtask

  task automatic expect_frame(input string tag, input int p0, input logic [7:0] d,
                              input logic pe, input logic fe, input logic bk);
    check_eq({tag, "_npulse"}, pulses - p0, 1);
    check_eq({tag, "_dout"}, dout, d);
    check_eq({tag, "_perr"}, parity_err, pe);
    check_eq({tag, "_ferr"}, frame_err, fe);
    check_eq({tag, "_brk"}, break_det, bk);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check_eq({tag, "_dout"}, dout, 0);
    check_eq({tag, "_done"}, rx_done_tick, 0);
    check_eq({tag, "_perr"}, parity_err, 0);
    check_eq({tag, "_ferr"}, frame_err, 0);
    check_eq({tag, "_brk"}, break_det, 0);
  endtask

  initial begin
    int p0;
    int base;
    int d;
    rx = 1'b1;
    reset = 1'b1;
    set_cfg(4'd8, 2'b00, 1'b0);
    repeat (5) @(negedge clk);
    expect_reset_outputs("rst");
    reset = 1'b0;
    idle_bits(2);

    // 8N1 0xA5, pulse must land around the centre of the stop bit
    p0 = pulses;
    send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    expect_frame("8n1_a5", p0, 8'hA5, 1'b0, 1'b0, 1'b0);
    d = last_pulse_cyc - stop_start;
    check_eq("8n1_pulse_pos", (d >= 30 && d <= 52), 1);

    // 7E2 0x41, correct and flipped parity
    set_cfg(4'd7, 2'b01, 1'b1);
    p0 = pulses;
    send_frame(9'h041, 7, 1, 1'b0, 1'b1, 1'b1);
    d = last_pulse_cyc - stop_start;
    idle_bits(1);
    expect_frame("7e2_ok", p0, 8'h41, 1'b0, 1'b0, 1'b0);
    check_eq("7e2_pulse_pos", (d >= 30 && d <= 52), 1);
    p0 = pulses;
    send_frame(9'h041, 7, 1, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    expect_frame("7e2_bad", p0, 8'h41, 1'b1, 1'b0, 1'b0);

    // 8O1 0x07, correct odd parity (bit 0)
    set_cfg(4'd8, 2'b10, 1'b0);
    p0 = pulses;
    send_frame(9'h007, 8, 2, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    expect_frame("8o1_07", p0, 8'h07, 1'b0, 1'b0, 1'b0);

    // quarter-bit low glitch on idle line, then a real frame
    set_cfg(4'd8, 2'b00, 1'b0);
    p0 = pulses;
    rx = 1'b0;
    repeat (BIT_CLK / 4) @(negedge clk);
    idle_bits(3);
    check_eq("glitch_nopulse", pulses - p0, 0);
    send_frame(9'h03C, 8, 0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    expect_frame("after_glitch_3c", p0, 8'h3C, 1'b0, 1'b0, 1'b0);

    // single-tick low glitch near the centre of data bit 3 of 0xFF
    p0 = pulses;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (36) @(negedge clk);
    rx = 1'b0;
    repeat (TPB) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLK - 36 - TPB) @(negedge clk);
    for (int i = 4; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(1);
    expect_frame("vote_ff", p0, 8'hFF, 1'b0, 1'b0, 1'b0);

    // stop bit low with nonzero data: framing error only
    p0 = pulses;
    send_frame(9'h080, 8, 0, 1'b0, 1'b0, 1'b0);
    idle_bits(2);
    expect_frame("ferr_80", p0, 8'h80, 1'b0, 1'b1, 1'b0);

    // out-of-range dbits falls back to 8
    set_cfg(4'd3, 2'b00, 1'b0);
    p0 = pulses;
    send_frame(9'h0C3, 8, 0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    expect_frame("dbits3_c3", p0, 8'hC3, 1'b0, 1'b0, 1'b0);

    // break: line low for two frame times
    set_cfg(4'd8, 2'b00, 1'b0);
    p0 = pulses;
    rx = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    idle_bits(2);
    expect_frame("break", p0, 8'h00, 1'b0, 1'b1, 1'b1);
    p0 = pulses;
    idle_bits(2);
    check_eq("break_nopulse", pulses - p0, 0);
    send_frame(9'h055, 8, 0, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    expect_frame("after_break_55", p0, 8'h55, 1'b0, 1'b0, 1'b0);

    // back-to-back 0x12, 0x34, then reset in the middle of a third frame
    p0 = pulses;
    base = cap_q.size();
    send_frame(9'h012, 8, 0, 1'b0, 1'b0, 1'b1);
    send_frame(9'h034, 8, 0, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    expect_reset_outputs("midrst");
    reset = 1'b0;
    idle_bits(12);
    check_eq("b2b_npulse", pulses - p0, 2);
    check_eq("b2b_byte0", cap_q[base], 8'h12);
    check_eq("b2b_byte1", cap_q[base + 1], 8'h34);
    expect_reset_outputs("post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
